// File: rtl/dvfs_sequencer.sv
// rtl/dvfs_sequencer.sv - orders frequency/voltage changes for core1, core2 and mem domains.
// DVFS_VSTEP_EN: defined = one voltage code per step; undefined = whole voltage target in one step.
module dvfs_sequencer #(
  parameter int VSETTLE = 16,
  parameter int FSETTLE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] tgt_v,
  input  logic [8:0] tgt_f,
  input  logic       tgt_ps,
  output logic [5:0] cur_v,
  output logic [8:0] cur_f,
  output logic       ps_out,
  output logic       busy,
  output logic       done
);

  localparam logic [5:0] V_RST    = 6'b010101;
  localparam logic [8:0] F_RST    = 9'b010010010;
  localparam logic [7:0] VSET_M1  = 8'(VSETTLE - 1);
  localparam logic [7:0] FSET_M1  = 8'(FSETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_F_DOWN, S_F_WAIT, S_V_STEP, S_V_WAIT, S_F_UP, S_F_WAIT2, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] prv_q, prv_d;
  logic [15:0] snap_q, snap_d;
  logic [5:0]  cur_v_q, cur_v_d;
  logic [8:0]  cur_f_q, cur_f_d;
  logic        ps_q, ps_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [15:0] tgt_all;
  logic [15:0] cur_all;
  logic [5:0]  snap_v;
  logic [8:0]  snap_f;
  logic        snap_ps;
  logic [8:0]  f_lower;
  logic [8:0]  f_raise;
  logic [5:0]  v_next;

  assign tgt_all = {tgt_v, tgt_f, tgt_ps};
  assign cur_all = {cur_v_q, cur_f_q, ps_q};
  assign snap_v  = snap_q[15:10];
  assign snap_f  = snap_q[9:1];
  assign snap_ps = snap_q[0];

  // Per-domain frequency merge: only domains moving in the phase's direction take the snapshot.
  function automatic logic [8:0] f_merge(input logic [8:0] cur, input logic [8:0] tgt,
                                         input logic go_down);
    logic [8:0] r;
    r = cur;
    for (int d = 0; d < 3; d++) begin
      if (go_down ? (tgt[3*d +: 3] < cur[3*d +: 3]) : (tgt[3*d +: 3] > cur[3*d +: 3]))
        r[3*d +: 3] = tgt[3*d +: 3];
    end
    return r;
  endfunction

  function automatic logic [5:0] v_toward(input logic [5:0] cur, input logic [5:0] tgt);
    logic [5:0] r;
    r = cur;
    for (int d = 0; d < 3; d++) begin
      if (tgt[2*d +: 2] > cur[2*d +: 2])
        r[2*d +: 2] = cur[2*d +: 2] + 2'd1;
      else if (tgt[2*d +: 2] < cur[2*d +: 2])
        r[2*d +: 2] = cur[2*d +: 2] - 2'd1;
    end
    return r;
  endfunction

  assign f_lower = f_merge(cur_f_q, snap_f, 1'b1);
  assign f_raise = f_merge(cur_f_q, snap_f, 1'b0);

`ifdef DVFS_VSTEP_EN
  assign v_next = v_toward(cur_v_q, snap_v);
`else
  assign v_next = snap_v;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prv_d   = tgt_all;
    snap_d  = snap_q;
    cur_v_d = cur_v_q;
    cur_f_d = cur_f_q;
    ps_d    = ps_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Two equal samples in a row count as a stable target.
        if (tgt_all == prv_q && tgt_all != cur_all) begin
          snap_d  = tgt_all;
          busy_d  = 1'b1;
          state_d = S_F_DOWN;
        end
      end
      S_F_DOWN: begin
        if (f_lower != cur_f_q) begin
          cur_f_d = f_lower;
          cnt_d   = FSET_M1;
          state_d = S_F_WAIT;
        end else begin
          state_d = S_V_STEP;
        end
      end
      S_F_WAIT: begin
        if (cnt_q == 8'd0) state_d = S_V_STEP;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_V_STEP: begin
        if (cur_v_q == snap_v) begin
          state_d = S_F_UP;
        end else begin
          cur_v_d = v_next;
          cnt_d   = VSET_M1;
          state_d = S_V_WAIT;
        end
      end
      S_V_WAIT: begin
        if (cnt_q == 8'd0) state_d = S_V_STEP;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_F_UP: begin
        if (f_raise != cur_f_q) begin
          cur_f_d = f_raise;
          cnt_d   = FSET_M1;
          state_d = S_F_WAIT2;
        end else begin
          ps_d    = snap_ps;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_F_WAIT2: begin
        if (cnt_q == 8'd0) begin
          ps_d    = snap_ps;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_DONE: begin
        // done and ps_out were registered on entry so they coincide with the last busy cycle.
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      prv_q   <= {V_RST, F_RST, 1'b0};
      snap_q  <= {V_RST, F_RST, 1'b0};
      cur_v_q <= V_RST;
      cur_f_q <= F_RST;
      ps_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prv_q   <= prv_d;
      snap_q  <= snap_d;
      cur_v_q <= cur_v_d;
      cur_f_q <= cur_f_d;
      ps_q    <= ps_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign cur_v  = cur_v_q;
  assign cur_f  = cur_f_q;
  assign ps_out = ps_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_dvfs_sequencer.sv
// tb/tb_dvfs_sequencer.sv - randomized bench for dvfs_sequencer against a per-cycle timeline model.
module tb_dvfs_sequencer;

  localparam int VS = 16;
  localparam int FS = 4;
  localparam logic [15:0] RST_VAL = {6'b010101, 9'b010010010, 1'b0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] tgt_v = RST_VAL[15:10];
  logic [8:0] tgt_f = RST_VAL[9:1];
  logic       tgt_ps = 1'b0;
  logic [5:0] cur_v;
  logic [8:0] cur_f;
  logic       ps_out, busy, done;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] m_cur = RST_VAL;

  dvfs_sequencer #(.VSETTLE(VS), .FSETTLE(FS)) dut (
    .clk(clk), .rst_n(rst_n), .tgt_v(tgt_v), .tgt_f(tgt_f), .tgt_ps(tgt_ps),
    .cur_v(cur_v), .cur_f(cur_f), .ps_out(ps_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [17:0] obs();
    return {cur_v, cur_f, ps_out, busy, done};
  endfunction

  function automatic logic [17:0] mk(input logic [15:0] s, input logic b, input logic d);
    return {s, b, d};
  endfunction

  // Domain i of a packed code vector as a plain integer
  function automatic int fld(input logic [8:0] x, input int w, input int i);
    return int'((x >> (w * i)) & ((9'd1 << w) - 9'd1));
  endfunction

  task automatic drive(input logic [15:0] t);
    tgt_v  = t[15:10];
    tgt_f  = t[9:1];
    tgt_ps = t[0];
  endtask

  // Timeline of outputs, one entry per cycle after the snapshot edge, built phase by phase.
  task automatic run_seq(input logic [15:0] snap, input bit sync, input int mid_idx,
                         input logic [15:0] mid_tgt, input string name);
    logic [17:0] tr[$];
    logic [5:0] v;
    logic [8:0] f, fn;
    logic ps;
    int steps;
    v = m_cur[15:10]; f = m_cur[9:1]; ps = m_cur[0];
    tr.push_back(mk({v, f, ps}, 1, 0));
    fn = f;
    for (int d = 0; d < 3; d++)
      if (fld(snap[9:1], 3, d) < fld(f, 3, d)) fn[3*d +: 3] = snap[1 + 3*d +: 3];
    if (fn != f) begin
      f = fn;
      repeat (FS) tr.push_back(mk({v, f, ps}, 1, 0));
    end
    steps = 0;
    while (1) begin
      tr.push_back(mk({v, f, ps}, 1, 0));
      if (v == snap[15:10] || steps > 8) break;
`ifdef DVFS_VSTEP_EN
      for (int d = 0; d < 3; d++) begin
        int c, t;
        c = fld({3'b0, v}, 2, d); t = fld({3'b0, snap[15:10]}, 2, d);
        c = c + ((t > c) ? 1 : (t < c) ? -1 : 0);
        v[2*d +: 2] = 2'(c);
      end
`else
      v = snap[15:10];
`endif
      steps++;
      repeat (VS) tr.push_back(mk({v, f, ps}, 1, 0));
    end
    tr.push_back(mk({v, f, ps}, 1, 0));
    if (f != snap[9:1]) begin
      f = snap[9:1];
      repeat (FS) tr.push_back(mk({v, f, ps}, 1, 0));
    end
    ps = snap[0];
    tr.push_back(mk({v, f, ps}, 1, 1));
    tr.push_back(mk({v, f, ps}, 0, 0));
    m_cur = {v, f, ps};

    if (sync) begin
      @(negedge clk);
      drive(snap);
      @(posedge clk);
      @(posedge clk);
    end
    for (int i = 0; i < tr.size(); i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs() !== tr[i]) begin
        n_err++;
        $display("FAIL %s cycle %0d: got v=%b f=%b ps=%b busy=%b done=%b, required v=%b f=%b ps=%b busy=%b done=%b",
                 name, i, cur_v, cur_f, ps_out, busy, done,
                 tr[i][17:12], tr[i][11:3], tr[i][2], tr[i][1], tr[i][0]);
      end
      if (i == mid_idx) drive(mid_tgt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(RST_VAL);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs() !== {RST_VAL, 2'b00}) begin
      n_err++;
      $display("FAIL reset_state: got %b, required %b", obs(), {RST_VAL, 2'b00});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs() !== {RST_VAL, 2'b00}) begin
        n_err++;
        $display("FAIL reset_idle cycle %0d: got %b, required %b", i, obs(), {RST_VAL, 2'b00});
      end
    end
    m_cur = RST_VAL;
  endtask

  task automatic test_directed();
    run_seq({6'b111111, 9'b111111111, 1'b0}, 1, -1, 16'h0, "up_all");
    run_seq({6'b000000, 9'b000000000, 1'b1}, 1, -1, 16'h0, "down_all_ps");
  endtask

  task automatic test_toggle();
    logic [15:0] a, b;
    a = m_cur ^ 16'hFFFF;
    b = m_cur ^ 16'h0402;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive((i % 2 == 0) ? a : b);
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        n_err++;
        $display("FAIL toggle cycle %0d: got busy=%b done=%b, required busy=0 done=0", i, busy, done);
      end
    end
    run_seq(a, 1, -1, 16'h0, "after_toggle");
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, b;
    a = m_cur ^ (16'($urandom_range(1, 65535)));
    b = a ^ (16'($urandom_range(1, 65535)));
    run_seq(a, 1, 12, b, "seq_first");
    run_seq(b, 0, -1, 16'h0, "seq_second");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive({6'b111111, m_cur[9:1], 1'b1});
    @(posedge clk);
    @(posedge clk);
    repeat (6) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_busy: got busy=%b, required 1", busy);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== {RST_VAL, 2'b00}) begin
      n_err++;
      $display("FAIL reset_mid_async: got %b, required %b", obs(), {RST_VAL, 2'b00});
    end
    drive(RST_VAL);
    @(negedge clk);
    rst_n = 1'b1;
    m_cur = RST_VAL;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs() !== {RST_VAL, 2'b00}) begin
        n_err++;
        $display("FAIL reset_mid_after cycle %0d: got %b, required %b", i, obs(), {RST_VAL, 2'b00});
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] t;
    for (int k = 0; k < 25; k++) begin
      t = 16'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk);
        drive(m_cur);
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          n_cmp++;
          if (obs() !== {m_cur, 2'b00}) begin
            n_err++;
            $display("FAIL rand_equal iter %0d cycle %0d: got %b, required %b", k, i, obs(), {m_cur, 2'b00});
          end
        end
      end else begin
        if (t == m_cur) t = t ^ 16'h0002;
        run_seq(t, 1, -1, 16'h0, "random");
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_toggle();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
